user_obi_copy_mgr: RTL and testbench
====================================

Name: user_obi_copy_mgr

Overview:
- OBI manager block for the user domain. It drives the user manager port toward the Croc interconnect, which is otherwise tied off.
- Software configures it through a small OBI subordinate register window: source address, destination address and word count.
- Once started, it copies the block word-by-word over the manager port, with one read followed by one write.
- It reports busy, done and error status and raises an optional interrupt on completion.

Parameters:
- MaxLenWidth, 16, width of the LEN register (word count); the largest copy is 2^MaxLenWidth-1 words.
- AddrOffsetBits, 2, address bits [AddrOffsetBits+1:2] select one of the 4 registers.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-high.
- cfg_obi_req_i  in  sbr_obi_req_t  register-window subordinate request.
- cfg_obi_rsp_o  out  sbr_obi_rsp_t  register-window subordinate response.
- mgr_obi_req_o  out  mgr_obi_req_t  copy-engine manager request.
- mgr_obi_rsp_i  in  mgr_obi_rsp_t  copy-engine manager response.
- irq_o  out  1  completion interrupt, level, active-high.

Behaviour:
- Register map, word offsets:
  - 0x0 SRC: RW, 32 bit.
  - 0x4 DST: RW, 32 bit.
  - 0x8 LEN: RW, MaxLenWidth bits, zero-extended on read.
  - 0xC CTRL/STAT:
    - Write: bit0 START, bit1 CLEAR (clears done, error, irq).
    - Read: bit0 busy, bit1 done, bit2 error, bits[31:16] index of the word being copied.
- Subordinate handshake:
  - gnt is tied 1.
  - rvalid is asserted exactly 1 cycle after each accepted req.
  - rid equals the latched aid; rdata holds the read value.
  - err is always 0.
  - Writes honour be per byte.
- SRC, DST and LEN writes are ignored while busy; the bus still responds normally.
- Reset values:
  - All registers 0; busy, done and error 0.
  - cfg_obi_rsp_o all 0.
  - mgr_obi_req_o all 0 (req=0).
  - irq_o 0.
  - FSM in IDLE.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT.
  - IDLE: on START with LEN!=0, set busy=1, done=0, error=0, idx=0, then go to RD_REQ. On START with LEN==0, set done=1 in the next cycle and stay in IDLE.
  - RD_REQ: drive req=1, we=0, be=4'hF, addr=SRC+4*idx, aid=0. The address wraps modulo 2^32. Hold all fields stable until gnt. On gnt, go to RD_WAIT; a request accepted this way is never retracted.
  - RD_WAIT: on rvalid, capture rdata. If r.err, go to error termination; otherwise go to WR_REQ.
  - WR_REQ: drive req=1, we=1, be=4'hF, wdata=captured word, addr=DST+4*idx. Hold until gnt, then go to WR_WAIT.
  - WR_WAIT: on rvalid with r.err, go to error termination. Otherwise, if idx==LEN-1, set busy=0, done=1 and go to IDLE; else idx++ and go to RD_REQ.
  - Error termination: busy=0, error=1, done=1, go to IDLE. idx is held for software inspection.
- Manager port:
  - At most 1 outstanding transaction.
  - rready is tied 1.
  - rvalid arriving in a state other than RD_WAIT or WR_WAIT is ignored.
- START while busy is ignored.
- START and CLEAR in the same write: CLEAR applies first, then START.
- Minimum cost per word: 4 cycles (zero-wait interconnect, gnt in the same cycle as req).
- Reset asserted mid-copy: everything returns immediately to the reset values, and any in-flight bus response is discarded after reset.

Optional Feature:
- USER_OBI_COPY_IRQ_EN defined:
  - irq_o is a registered copy of (done | error).
  - It asserts the cycle after done is set and stays high until a CLEAR write.
- Not defined:
  - irq_o is tied to 0; status remains pollable via CTRL/STAT.

Test Plan:
- Basic copy: SRC=0x1000_0000, DST=0x1000_0100, LEN=4 with memory words 0x11..0x44, write START. Required: 4 reads then 4 writes at incrementing addresses, DST holds 0x11,0x22,0x33,0x44, STAT reads 0x0003_0002 (idx=3, done), busy=0.
- LEN=0 then START: no mgr req ever asserted; STAT=0x2 one cycle later.
- Read error on word 2 of 5 (memory returns err): copy halts, STAT bit2=1, bit1=1, idx=2, only 2 writes issued.
- gnt stall: hold gnt low for 7 cycles on the first write. Required: addr, we and wdata stable throughout; copy still completes correctly.
- Busy protection: write START and LEN=9 during a copy with LEN=3. Required: exactly 3 words copied; LEN reads back 3.
- With USER_OBI_COPY_IRQ_EN: irq_o rises the cycle after done and falls the cycle after a CLEAR write. Without the macro: irq_o stays 0 throughout.

Source files
------------

// File: rtl/user_obi_copy_mgr.sv
// OBI copy engine for the user domain: register window (SRC/DST/LEN/CTRL) plus a manager port
// that copies LEN words with one read and one write per word. `define USER_OBI_COPY_IRQ_EN for irq_o.
// Packed OBI layouts: req = {req, we, be[3:0], addr[31:0], wdata[31:0], aid}; rsp = {gnt, rvalid, rdata[31:0], rid, err}.
module user_obi_copy_mgr #(
  parameter int unsigned MaxLenWidth    = 16,
  parameter int unsigned AddrOffsetBits = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [70:0] cfg_obi_req_i,
  output logic [35:0] cfg_obi_rsp_o,
  output logic [70:0] mgr_obi_req_o,
  input  logic [35:0] mgr_obi_rsp_i,
  output logic        irq_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    WR_WAIT = 3'd4
  } state_e;

  function automatic logic [31:0] apply_be(input logic [31:0] old_v, input logic [31:0] new_v,
                                           input logic [3:0] be);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_v[8*b +: 8];
      else       res[8*b +: 8] = old_v[8*b +: 8];
    end
    return res;
  endfunction

  logic                      cfg_req_s, cfg_we_s, cfg_aid_s, cfg_gnt_s, cfg_accept_s, wr_acc_s;
  logic [3:0]                cfg_be_s;
  logic [31:0]               cfg_addr_s, cfg_wdata_s;
  logic [AddrOffsetBits-1:0] sel_s;
  logic                      mgr_gnt_s, mgr_rvalid_s, mgr_err_s, mgr_rid_s;
  logic [31:0]               mgr_rdata_s;

  assign cfg_req_s    = cfg_obi_req_i[70];
  assign cfg_we_s     = cfg_obi_req_i[69];
  assign cfg_be_s     = cfg_obi_req_i[68:65];
  assign cfg_addr_s   = cfg_obi_req_i[64:33];
  assign cfg_wdata_s  = cfg_obi_req_i[32:1];
  assign cfg_aid_s    = cfg_obi_req_i[0];
  assign mgr_gnt_s    = mgr_obi_rsp_i[35];
  assign mgr_rvalid_s = mgr_obi_rsp_i[34];
  assign mgr_rdata_s  = mgr_obi_rsp_i[33:2];
  assign mgr_rid_s    = mgr_obi_rsp_i[1];
  assign mgr_err_s    = mgr_obi_rsp_i[0];

  logic unused_s;
  assign unused_s = ^{cfg_addr_s, mgr_rid_s};

  // gnt is permanently high outside reset, which keeps the response all-zero while rst_i is held
  assign cfg_gnt_s    = ~rst_i;
  assign cfg_accept_s = cfg_req_s & cfg_gnt_s;
  assign wr_acc_s     = cfg_accept_s & cfg_we_s;
  assign sel_s        = cfg_addr_s[AddrOffsetBits+1:2];

  state_e                  state_r, state_next_s;
  logic [31:0]             src_r, dst_r, rbuf_r, rdata_r, rd_val_s, idx_ext_s;
  logic [MaxLenWidth-1:0]  len_r, idx_r;
  logic                    busy_r, done_r, error_r, rvalid_r, rid_r;
  logic                    start_s, clear_s, last_s;

  assign idx_ext_s = 32'(idx_r);
  assign last_s    = (idx_r == (len_r - MaxLenWidth'(1)));

  // Decode CTRL write strobes; START is dropped while a copy is running
  always_comb begin
    start_s = 1'b0;
    clear_s = 1'b0;
    if (wr_acc_s && (sel_s == AddrOffsetBits'(3)) && cfg_be_s[0]) begin
      start_s = cfg_wdata_s[0] & ~busy_r;
      clear_s = cfg_wdata_s[1];
    end else begin
      start_s = 1'b0;
      clear_s = 1'b0;
    end
  end

  // Register read mux
  always_comb begin
    rd_val_s = 32'd0;
    case (sel_s)
      AddrOffsetBits'(0): rd_val_s = src_r;
      AddrOffsetBits'(1): rd_val_s = dst_r;
      AddrOffsetBits'(2): rd_val_s = 32'(len_r);
      AddrOffsetBits'(3): rd_val_s = {idx_ext_s[15:0], 13'd0, error_r, done_r, busy_r};
      default:            rd_val_s = 32'd0;
    endcase
  end

  // Subordinate response: one-cycle rvalid with echoed aid
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_r <= 1'b0;
      rid_r    <= 1'b0;
      rdata_r  <= 32'd0;
    end else begin
      rvalid_r <= cfg_accept_s;
      if (cfg_accept_s) begin
        rid_r   <= cfg_aid_s;
        rdata_r <= cfg_we_s ? 32'd0 : rd_val_s;
      end
    end
  end

  assign cfg_obi_rsp_o = {cfg_gnt_s, rvalid_r, rdata_r, rid_r, 1'b0};

  // Configuration registers, frozen while busy
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      src_r <= 32'd0;
      dst_r <= 32'd0;
      len_r <= '0;
    end else if (wr_acc_s && !busy_r) begin
      case (sel_s)
        AddrOffsetBits'(0): src_r <= apply_be(src_r, cfg_wdata_s, cfg_be_s);
        AddrOffsetBits'(1): dst_r <= apply_be(dst_r, cfg_wdata_s, cfg_be_s);
        AddrOffsetBits'(2): len_r <= MaxLenWidth'(apply_be(32'(len_r), cfg_wdata_s, cfg_be_s));
        default: ;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_r <= IDLE;
    else       state_r <= state_next_s;
  end

  // FSM next state
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_s && (len_r != '0)) state_next_s = RD_REQ;
        else                          state_next_s = IDLE;
      end
      RD_REQ: begin
        if (mgr_gnt_s) state_next_s = RD_WAIT;
        else           state_next_s = RD_REQ;
      end
      RD_WAIT: begin
        if (mgr_rvalid_s) state_next_s = mgr_err_s ? IDLE : WR_REQ;
        else              state_next_s = RD_WAIT;
      end
      WR_REQ: begin
        if (mgr_gnt_s) state_next_s = WR_WAIT;
        else           state_next_s = WR_REQ;
      end
      WR_WAIT: begin
        if (mgr_rvalid_s) state_next_s = (mgr_err_s || last_s) ? IDLE : RD_REQ;
        else              state_next_s = WR_WAIT;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // FSM outputs: manager request fields depend only on registered state, so they hold until gnt
  always_comb begin
    mgr_obi_req_o = 71'd0;
    case (state_r)
      RD_REQ:  mgr_obi_req_o = {1'b1, 1'b0, 4'hF, src_r + (idx_ext_s << 2), 32'd0, 1'b0};
      WR_REQ:  mgr_obi_req_o = {1'b1, 1'b1, 4'hF, dst_r + (idx_ext_s << 2), rbuf_r, 1'b0};
      default: mgr_obi_req_o = 71'd0;
    endcase
  end

  // Status, word index and read-data buffer; CLEAR is applied before START
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      error_r <= 1'b0;
      idx_r   <= '0;
      rbuf_r  <= 32'd0;
    end else begin
      if (clear_s) begin
        done_r  <= 1'b0;
        error_r <= 1'b0;
      end
      if (start_s) begin
        if (len_r != '0) begin
          busy_r  <= 1'b1;
          done_r  <= 1'b0;
          error_r <= 1'b0;
          idx_r   <= '0;
        end else begin
          done_r <= 1'b1;
        end
      end
      case (state_r)
        RD_WAIT: begin
          if (mgr_rvalid_s) begin
            rbuf_r <= mgr_rdata_s;
            if (mgr_err_s) begin
              busy_r  <= 1'b0;
              error_r <= 1'b1;
              done_r  <= 1'b1;
            end
          end
        end
        WR_WAIT: begin
          if (mgr_rvalid_s) begin
            if (mgr_err_s) begin
              busy_r  <= 1'b0;
              error_r <= 1'b1;
              done_r  <= 1'b1;
            end else if (last_s) begin
              busy_r <= 1'b0;
              done_r <= 1'b1;
            end else begin
              idx_r <= idx_r + MaxLenWidth'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef USER_OBI_COPY_IRQ_EN
  logic irq_r;
  // Level interrupt follows completion status one cycle late
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) irq_r <= 1'b0;
    else       irq_r <= done_r | error_r;
  end
  assign irq_o = irq_r;
`else
  assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_user_obi_copy_mgr.sv
// Scoreboard bench for user_obi_copy_mgr: a memory model on the manager port checks each
// transaction against queued expectations; register reads are checked against a read queue.
module tb_user_obi_copy_mgr;

`ifdef USER_OBI_COPY_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  localparam logic [31:0] A_SRC = 32'h0, A_DST = 32'h4, A_LEN = 32'h8, A_CTRL = 32'hC;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        c_req = 1'b0, c_we = 1'b0, c_aid = 1'b0, aid_tog = 1'b0;
  logic [3:0]  c_be = 4'h0;
  logic [31:0] c_addr = 32'h0, c_wdata = 32'h0;
  logic        m_gnt = 1'b0, m_rvalid = 1'b0, m_err = 1'b0;
  logic [31:0] m_rdata = 32'h0;
  logic [70:0] cfg_req, mgr_req;
  logic [35:0] cfg_rsp, mgr_rsp;
  logic        irq;

  int          checks = 0;
  int          errors = 0;
  int          stall_cnt = 0;
  int          irq_hi_cnt = 0;
  logic [31:0] err_addr = 32'hFFFF_FFFF;
  logic [31:0] mem [logic [31:0]];
  txn_t        exp_q [$];
  logic [31:0] rd_q [$];

  assign cfg_req = {c_req, c_we, c_be, c_addr, c_wdata, c_aid};
  assign mgr_rsp = {m_gnt, m_rvalid, m_rdata, 1'b0, m_err};

  user_obi_copy_mgr dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cfg_obi_req_i(cfg_req),
    .cfg_obi_rsp_o(cfg_rsp),
    .mgr_obi_req_o(mgr_req),
    .mgr_obi_rsp_i(mgr_rsp),
    .irq_o        (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  // Queue the expected manager transactions of a copy; stops after the read at err_word
  task automatic push_copy(input logic [31:0] s, input logic [31:0] d, input int n, input int err_word);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{1'b0, s + 32'(4 * i), 32'h0});
      if (i == err_word) break;
      exp_q.push_back('{1'b1, d + 32'(4 * i), mem_rd(s + 32'(4 * i))});
    end
  endtask

  // Manager-side memory: decides gnt at negedge, answers one cycle after acceptance
  initial begin
    logic        pend = 1'b0, pend_err = 1'b0;
    logic [31:0] pend_data = 32'h0;
    txn_t        t;
    forever begin
      @(negedge clk);
      m_rvalid = pend; m_rdata = pend_data; m_err = pend_err;
      pend = 1'b0; pend_data = 32'h0; pend_err = 1'b0;
      m_gnt = 1'b0;
      if (irq) irq_hi_cnt++;
      if (!rst && mgr_req[70]) begin
        if (mgr_req[69] && stall_cnt > 0) begin
          stall_cnt--;
          if (exp_q.size() > 0) begin
            check("stall_we", 32'(mgr_req[69]), 32'(exp_q[0].we));
            check("stall_addr", mgr_req[64:33], exp_q[0].addr);
            check("stall_wdata", mgr_req[32:1], exp_q[0].data);
          end
        end else begin
          m_gnt = 1'b1;
          if (exp_q.size() == 0) begin
            check("extra_txn", 32'h1, 32'h0);
          end else begin
            t = exp_q.pop_front();
            check("txn_we", 32'(mgr_req[69]), 32'(t.we));
            check("txn_addr", mgr_req[64:33], t.addr);
            check("txn_be", 32'(mgr_req[68:65]), 32'hF);
            if (t.we) check("txn_wdata", mgr_req[32:1], t.data);
          end
          pend = 1'b1;
          if (mgr_req[69]) mem[mgr_req[64:33]] = mgr_req[32:1];
          else begin
            pend_data = mem_rd(mgr_req[64:33]);
            pend_err  = (mgr_req[64:33] == err_addr);
          end
        end
      end
    end
  end

  task automatic cfg_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    logic exp_aid;
    c_req = 1'b1; c_we = 1'b1; c_be = be; c_addr = a; c_wdata = d;
    c_aid = aid_tog; exp_aid = aid_tog; aid_tog = ~aid_tog;
    @(posedge clk); #1;
    c_req = 1'b0; c_we = 1'b0;
    check("wr_rvalid", 32'(cfg_rsp[34]), 32'h1);
    check("wr_rid", 32'(cfg_rsp[1]), 32'(exp_aid));
  endtask

  task automatic cfg_read_raw(input logic [31:0] a, output logic [31:0] d, output logic aid);
    c_req = 1'b1; c_we = 1'b0; c_be = 4'hF; c_addr = a; c_wdata = 32'h0;
    c_aid = aid_tog; aid = aid_tog; aid_tog = ~aid_tog;
    @(posedge clk); #1;
    c_req = 1'b0;
    d = cfg_rsp[33:2];
  endtask

  task automatic cfg_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic        aid;
    rd_q.push_back(exp);
    cfg_read_raw(a, d, aid);
    check(tag, d, rd_q.pop_front());
    check("rd_rvalid", 32'(cfg_rsp[34]), 32'h1);
    check("rd_rid", 32'(cfg_rsp[1]), 32'(aid));
    check("rd_err", 32'(cfg_rsp[0]), 32'h0);
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] d;
    logic        aid;
    d = 32'h1;
    for (int i = 0; i < 200 && d[0]; i++) cfg_read_raw(A_CTRL, d, aid);
    check(tag, 32'(d[0]), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_cfg_rsp", 32'(|cfg_rsp), 32'h0);
    check("rst_mgr_req", 32'(|mgr_req), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("gnt_tied", 32'(cfg_rsp[35]), 32'h1);
    cfg_rd("rst_src", A_SRC, 32'h0);
    cfg_rd("rst_dst", A_DST, 32'h0);
    cfg_rd("rst_len", A_LEN, 32'h0);
    cfg_rd("rst_stat", A_CTRL, 32'h0);

    // LEN=0 start: done only, no bus traffic, interrupt timing
    cfg_write(A_CTRL, 32'h1, 4'hF);
    check("irq_not_yet", 32'(irq), 32'h0);
    cfg_rd("stat_len0", A_CTRL, 32'h2);
    check("irq_rise", 32'(irq), 32'(IRQ_ON));
    cfg_write(A_CTRL, 32'h2, 4'hF);
    check("irq_hold", 32'(irq), 32'(IRQ_ON));
    @(posedge clk); #1;
    check("irq_fall", 32'(irq), 32'h0);
    cfg_rd("stat_cleared", A_CTRL, 32'h0);

    // Basic 4-word copy
    for (int i = 0; i < 4; i++) mem[32'h1000_0000 + 32'(4 * i)] = 32'h11 * 32'(i + 1);
    cfg_write(A_SRC, 32'h1000_0000, 4'hF);
    cfg_write(A_DST, 32'h1000_0100, 4'hF);
    cfg_write(A_LEN, 32'h4, 4'hF);
    cfg_rd("dst_reg", A_DST, 32'h1000_0100);
    push_copy(32'h1000_0000, 32'h1000_0100, 4, -1);
    cfg_write(A_CTRL, 32'h1, 4'hF);
    wait_idle("basic_timeout");
    cfg_rd("basic_stat", A_CTRL, 32'h0003_0002);
    for (int i = 0; i < 4; i++) check("basic_mem", mem_rd(32'h1000_0100 + 32'(4 * i)), 32'h11 * 32'(i + 1));
    check("basic_q", 32'(exp_q.size()), 32'h0);

    // Read error on word 2 of 5
    for (int i = 0; i < 5; i++) begin
      mem[32'h2000_0000 + 32'(4 * i)] = 32'hC0DE_0000 + 32'(i);
      mem[32'h2000_0100 + 32'(4 * i)] = 32'hDEAD_BEEF;
    end
    err_addr = 32'h2000_0008;
    cfg_write(A_SRC, 32'h2000_0000, 4'hF);
    cfg_write(A_DST, 32'h2000_0100, 4'hF);
    cfg_write(A_LEN, 32'h5, 4'h3);
    push_copy(32'h2000_0000, 32'h2000_0100, 5, 2);
    cfg_write(A_CTRL, 32'h3, 4'hF);
    wait_idle("err_timeout");
    cfg_rd("err_stat", A_CTRL, 32'h0002_0006);
    check("err_q", 32'(exp_q.size()), 32'h0);
    check("err_mem1", mem_rd(32'h2000_0104), 32'hC0DE_0001);
    check("err_mem2", mem_rd(32'h2000_0108), 32'hDEAD_BEEF);
    check("err_irq", 32'(irq), 32'(IRQ_ON));
    err_addr = 32'hFFFF_FFFF;
    cfg_write(A_CTRL, 32'h2, 4'hF);

    // gnt held low for 7 cycles on the first write
    mem[32'h3000_0000] = 32'hA1A1_0001;
    mem[32'h3000_0004] = 32'hA2A2_0002;
    cfg_write(A_SRC, 32'h3000_0000, 4'hF);
    cfg_write(A_DST, 32'h3000_0100, 4'hF);
    cfg_write(A_LEN, 32'h2, 4'hF);
    push_copy(32'h3000_0000, 32'h3000_0100, 2, -1);
    stall_cnt = 7;
    cfg_write(A_CTRL, 32'h1, 4'hF);
    wait_idle("stall_timeout");
    cfg_rd("stall_stat", A_CTRL, 32'h0001_0002);
    check("stall_used", 32'(stall_cnt), 32'h0);
    check("stall_mem0", mem_rd(32'h3000_0100), 32'hA1A1_0001);
    check("stall_mem1", mem_rd(32'h3000_0104), 32'hA2A2_0002);
    check("stall_q", 32'(exp_q.size()), 32'h0);

    // Writes while busy are ignored
    for (int i = 0; i < 9; i++) mem[32'h4000_0000 + 32'(4 * i)] = 32'hB000_0000 + 32'(i);
    cfg_write(A_SRC, 32'h4000_0000, 4'hF);
    cfg_write(A_DST, 32'h4000_0100, 4'hF);
    cfg_write(A_LEN, 32'h3, 4'hF);
    push_copy(32'h4000_0000, 32'h4000_0100, 3, -1);
    cfg_write(A_CTRL, 32'h1, 4'hF);
    cfg_write(A_LEN, 32'h9, 4'hF);
    cfg_write(A_CTRL, 32'h1, 4'hF);
    cfg_write(A_SRC, 32'h5000_0000, 4'hF);
    wait_idle("busy_timeout");
    cfg_rd("busy_stat", A_CTRL, 32'h0002_0002);
    cfg_rd("busy_len", A_LEN, 32'h3);
    cfg_rd("busy_src", A_SRC, 32'h4000_0000);
    check("busy_q", 32'(exp_q.size()), 32'h0);
    check("busy_mem2", mem_rd(32'h4000_0108), 32'hB000_0002);

    // Reset in the middle of a copy
    cfg_write(A_SRC, 32'h6000_0000, 4'hF);
    push_copy(32'h6000_0000, 32'h4000_0100, 3, -1);
    cfg_write(A_CTRL, 32'h1, 4'hF);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_mgr", 32'(|mgr_req), 32'h0);
    check("mid_rst_cfg", 32'(|cfg_rsp), 32'h0);
    check("mid_rst_irq", 32'(irq), 32'h0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cfg_rd("post_rst_stat", A_CTRL, 32'h0);
    cfg_rd("post_rst_len", A_LEN, 32'h0);
    cfg_rd("post_rst_src", A_SRC, 32'h0);
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_q", 32'(exp_q.size()), 32'h0);

`ifndef USER_OBI_COPY_IRQ_EN
    check("irq_never", 32'(irq_hi_cnt), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
